// File: rtl/reg_file_param.sv
// reg_file_param: parametrised register file with optional hardwired-zero
// register 0, optional write-to-read bypass and a sequenced clear sweep
// (one register per cycle) that reports BUSY and flags dropped writes.
module reg_file_param #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [DATA_W-1:0] IN,
    input  logic [ADDR_W-1:0] INADDRESS,
    input  logic              WRITE,
    input  logic [ADDR_W-1:0] OUT1ADDRESS,
    input  logic [ADDR_W-1:0] OUT2ADDRESS,
    output logic [DATA_W-1:0] OUT1,
    output logic [DATA_W-1:0] OUT2,
    input  logic              CLEAR,
    output logic              BUSY,
    output logic              DROPPED
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_ptr;
    logic [DATA_W-1:0] r_regs [DEPTH];
    logic              r_dropped;

    logic              w_busy;
    logic              w_last;
    logic              w_zero_wa;
    logic              w_zero_ra1;
    logic              w_zero_ra2;
    logic              w_wr_en;
    logic              w_fwd1;
    logic              w_fwd2;

    assign w_busy     = (r_state == SWEEP);
    assign w_last     = (r_ptr == ADDR_W'(DEPTH - 1));
    assign w_zero_wa  = (ZERO_REG != 0) && (INADDRESS == '0);
    assign w_zero_ra1 = (ZERO_REG != 0) && (OUT1ADDRESS == '0);
    assign w_zero_ra2 = (ZERO_REG != 0) && (OUT2ADDRESS == '0);
    assign w_wr_en    = WRITE && !w_busy && !w_zero_wa;

    // Forwarding only when the write will actually land this edge.
    assign w_fwd1 = (BYPASS != 0) && RESET && w_wr_en && (INADDRESS == OUT1ADDRESS);
    assign w_fwd2 = (BYPASS != 0) && RESET && w_wr_en && (INADDRESS == OUT2ADDRESS);

    // Next-state logic for the clear sweep; CLEAR is ignored while sweeping.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (CLEAR)  w_next = SWEEP;
            SWEEP:   if (w_last) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (!RESET) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Sweep pointer: held at 0 while idle, advances one register per sweep cycle.
    always_ff @(posedge CLK) begin
        if (!RESET)                r_ptr <= '0;
        else if (r_state == IDLE)  r_ptr <= '0;
        else                       r_ptr <= r_ptr + 1'b1;
    end

    // Register storage: reset clears all, the sweep clears one, otherwise normal writes.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            for (int unsigned i = 0; i < DEPTH; i++) r_regs[i] <= '0;
        end else if (w_busy) begin
            r_regs[r_ptr] <= '0;
        end else if (w_wr_en) begin
            r_regs[INADDRESS] <= IN;
        end
    end

    // One-cycle flag for a write discarded because a sweep was in progress.
    always_ff @(posedge CLK) begin
        if (!RESET) r_dropped <= 1'b0;
        else        r_dropped <= WRITE && w_busy && !w_zero_wa;
    end

    // Combinational read ports with zero-register and bypass handling.
    always_comb begin
        OUT1 = r_regs[OUT1ADDRESS];
        OUT2 = r_regs[OUT2ADDRESS];
        if (w_fwd1)     OUT1 = IN;
        if (w_fwd2)     OUT2 = IN;
        if (w_zero_ra1) OUT1 = '0;
        if (w_zero_ra2) OUT2 = '0;
    end

    assign BUSY    = w_busy;
    assign DROPPED = r_dropped;

endmodule

// File: tb/tb_reg_file_param.sv
// Directed testbench for reg_file_param: one instance with default
// parameters (bypass on, no zero register) and one 16x16 instance with the
// zero register enabled and bypass disabled.
module tb_reg_file_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Instance A: defaults
    logic       a_rst, a_we, a_clr, a_busy, a_drop;
    logic [7:0] a_in, a_o1, a_o2;
    logic [2:0] a_wa, a_ra1, a_ra2;

    // Instance B: 16-bit data, 16 registers, zero register, no bypass
    logic        b_rst, b_we, b_clr, b_busy, b_drop;
    logic [15:0] b_in, b_o1, b_o2;
    logic [3:0]  b_wa, b_ra1, b_ra2;

    reg_file_param u_dut_a (
        .CLK(clk), .RESET(a_rst), .IN(a_in), .INADDRESS(a_wa), .WRITE(a_we),
        .OUT1ADDRESS(a_ra1), .OUT2ADDRESS(a_ra2), .OUT1(a_o1), .OUT2(a_o2),
        .CLEAR(a_clr), .BUSY(a_busy), .DROPPED(a_drop)
    );

    reg_file_param #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1), .BYPASS(0)) u_dut_b (
        .CLK(clk), .RESET(b_rst), .IN(b_in), .INADDRESS(b_wa), .WRITE(b_we),
        .OUT1ADDRESS(b_ra1), .OUT2ADDRESS(b_ra2), .OUT1(b_o1), .OUT2(b_o2),
        .CLEAR(b_clr), .BUSY(b_busy), .DROPPED(b_drop)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic a_write(input logic [2:0] addr, input logic [7:0] data);
        a_we = 1'b1; a_wa = addr; a_in = data;
        tick();
        a_we = 1'b0;
    endtask

    task automatic b_write(input logic [3:0] addr, input logic [15:0] data);
        b_we = 1'b1; b_wa = addr; b_in = data;
        tick();
        b_we = 1'b0;
    endtask

    int unsigned cnt;

    initial begin
        a_rst = 1'b0; a_we = 1'b0; a_clr = 1'b0; a_in = '0; a_wa = '0; a_ra1 = '0; a_ra2 = '0;
        b_rst = 1'b0; b_we = 1'b0; b_clr = 1'b0; b_in = '0; b_wa = '0; b_ra1 = '0; b_ra2 = '0;
        tick();
        a_rst = 1'b1; b_rst = 1'b1;
        #1;
        check("a_busy_after_reset", 32'(a_busy), 32'd0);
        check("a_drop_after_reset", 32'(a_drop), 32'd0);
        check("b_busy_after_reset", 32'(b_busy), 32'd0);

        // ---- Reset clears every register ----
        for (int i = 0; i < 8; i++) a_write(3'(i), 8'hFF);
        a_ra1 = 3'd3; #1;
        check("a_fill_ff_r3", 32'(a_o1), 32'hFF);
        a_rst = 1'b0;
        tick();
        a_rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a_ra1 = 3'(i); a_ra2 = 3'(7 - i); #1;
            check($sformatf("a_reset_out1_r%0d", i), 32'(a_o1), 32'd0);
            check($sformatf("a_reset_out2_r%0d", 7 - i), 32'(a_o2), 32'd0);
        end
        check("a_busy_post_rst", 32'(a_busy), 32'd0);
        check("a_drop_post_rst", 32'(a_drop), 32'd0);

        // ---- Bypass: value visible in the write cycle ----
        a_we = 1'b1; a_wa = 3'd2; a_in = 8'd95; a_ra1 = 3'd2; a_ra2 = 3'd3; #1;
        check("a_bypass_out1", 32'(a_o1), 32'd95);
        check("a_bypass_out2_other", 32'(a_o2), 32'd0);
        tick();
        a_we = 1'b0; #1;
        check("a_after_write_r2", 32'(a_o1), 32'd95);

        // ---- Sweep: fill 1..8 then clear one register per edge ----
        for (int i = 0; i < 8; i++) a_write(3'(i), 8'(i + 1));
        a_clr = 1'b1;
        tick();                 // E0
        a_clr = 1'b0;
        cnt = 0;
        for (int k = 1; k <= 8; k++) begin
            if (a_busy) cnt++;
            tick();             // Ek
            a_ra1 = 3'(k - 1);
            a_ra2 = 3'(k % 8);
            #1;
            check($sformatf("a_sweep_cleared_r%0d", k - 1), 32'(a_o1), 32'd0);
            if (k < 8)
                check($sformatf("a_sweep_kept_r%0d", k), 32'(a_o2), 32'(k + 1));
        end
        check("a_busy_cycles", cnt, 32'd8);
        check("a_busy_fell", 32'(a_busy), 32'd0);
        for (int i = 0; i < 8; i++) begin
            a_ra1 = 3'(i); #1;
            check($sformatf("a_swept_zero_r%0d", i), 32'(a_o1), 32'd0);
        end

        // ---- Write during sweep, write coincident with CLEAR ----
        for (int i = 0; i < 8; i++) a_write(3'(i), 8'(i + 1));
        a_we = 1'b1; a_wa = 3'd6; a_in = 8'd77; a_clr = 1'b1;
        tick();                 // E0: write performed
        a_we = 1'b0; a_clr = 1'b0;
        a_ra1 = 3'd6; #1;
        check("a_coincident_write_stored", 32'(a_o1), 32'd77);
        tick();                 // E1
        tick();                 // E2
        a_we = 1'b1; a_wa = 3'd5; a_in = 8'd28; a_ra1 = 3'd5; #1;
        check("a_no_bypass_when_busy", 32'(a_o1), 32'd6);
        check("a_drop_before", 32'(a_drop), 32'd0);
        tick();                 // E3: write dropped
        a_we = 1'b0; #1;
        check("a_drop_pulse", 32'(a_drop), 32'd1);
        check("a_r5_unchanged", 32'(a_o1), 32'd6);
        tick();                 // E4
        check("a_drop_one_cycle", 32'(a_drop), 32'd0);
        tick();                 // E5
        tick();                 // E6
        a_ra1 = 3'd6; #1;
        check("a_r6_before_clear", 32'(a_o1), 32'd77);
        tick();                 // E7
        check("a_r6_cleared", 32'(a_o1), 32'd0);
        a_clr = 1'b1;           // CLEAR at E8 must be ignored
        tick();                 // E8
        a_clr = 1'b0;
        check("a_busy_after_e8", 32'(a_busy), 32'd0);
        tick();
        check("a_clear_at_e8_ignored", 32'(a_busy), 32'd0);

        // ---- Instance B: no bypass ----
        b_ra1 = 4'd2; b_we = 1'b1; b_wa = 4'd2; b_in = 16'd95; #1;
        check("b_no_bypass_old", 32'(b_o1), 32'd0);
        tick();
        b_we = 1'b0; #1;
        check("b_after_edge", 32'(b_o1), 32'd95);

        // ---- Instance B: zero register ----
        b_write(4'd1, 16'd11);
        b_ra1 = 4'd0; b_we = 1'b1; b_wa = 4'd0; b_in = 16'd50; #1;
        check("b_r0_before", 32'(b_o1), 32'd0);
        tick();
        b_we = 1'b0; b_ra2 = 4'd1; #1;
        check("b_r0_after", 32'(b_o1), 32'd0);
        check("b_r0_no_drop", 32'(b_drop), 32'd0);
        check("b_r1_kept", 32'(b_o2), 32'd11);
        b_ra2 = 4'd2; #1;
        check("b_r2_kept", 32'(b_o2), 32'd95);

        // ---- Instance B: 16-bit data, 16-cycle sweep ----
        b_write(4'd15, 16'hBEEF);
        b_ra1 = 4'd15; #1;
        check("b_r15_beef", 32'(b_o1), 32'hBEEF);
        b_clr = 1'b1;
        tick();
        b_clr = 1'b0;
        cnt = 0;
        for (int c = 0; c < 40 && b_busy; c++) begin
            cnt++;
            tick();
        end
        check("b_busy_cycles", cnt, 32'd16);
        check("b_r15_swept", 32'(b_o1), 32'd0);

        // ---- Instance B: reset aborts a sweep ----
        b_write(4'd10, 16'h1234);
        b_write(4'd15, 16'hBEEF);
        b_clr = 1'b1;
        tick();                 // E0
        b_clr = 1'b0;
        for (int k = 0; k < 4; k++) tick();   // E1..E4
        b_ra1 = 4'd10; #1;
        check("b_r10_before_abort", 32'(b_o1), 32'h1234);
        check("b_busy_5th_cycle", 32'(b_busy), 32'd1);
        b_rst = 1'b0;
        tick();
        b_rst = 1'b1; #1;
        check("b_busy_after_abort", 32'(b_busy), 32'd0);
        for (int i = 0; i < 16; i++) begin
            b_ra1 = 4'(i); #1;
            check($sformatf("b_abort_zero_r%0d", i), 32'(b_o1), 32'd0);
        end
        tick();
        check("b_stays_idle", 32'(b_busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reg_file_param.md
# reg_file_param

Parametrised multi-width register file for the single-cycle processor datapath. It replaces the fixed 8x8 register file and adds:
- configurable data width and depth;
- an optional hardwired-zero register 0;
- optional write-to-read bypass;
- a sequenced clear operation (one register per cycle) with a busy/drop handshake.

It sits between the instruction decoder and the ALU.

## Interface
- DATA_W, 8, register and port data width (>=1)
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W registers
- ZERO_REG, 0, 1 = register 0 always reads 0 and ignores writes
- BYPASS, 1, 1 = a same-cycle write to a read address is forwarded to that read output

Ports:
- CLK  input  1  clock; all state changes on rising edge
- RESET  input  1  reset; synchronous, active-low
- IN  input  DATA_W  write data
- INADDRESS  input  ADDR_W  write address
- WRITE  input  1  write enable
- OUT1ADDRESS  input  ADDR_W  read port 1 address
- OUT2ADDRESS  input  ADDR_W  read port 2 address
- OUT1  output  DATA_W  read port 1 data, combinational
- OUT2  output  DATA_W  read port 2 data, combinational
- CLEAR  input  1  request a sequenced clear of all registers
- BUSY  output  1  clear sweep in progress, registered
- DROPPED  output  1  one-cycle pulse: previous-cycle write was discarded, registered

## Operation
- **Reset.** RESET low at a rising edge does all of the following in that single edge:
  - all DEPTH registers become 0;
  - FSM goes to IDLE and the sweep pointer to 0;
  - BUSY=0 and DROPPED=0.
  - RESET overrides WRITE and CLEAR.
  - Reset mid-sweep aborts the sweep.
- **FSM states.** IDLE and SWEEP.
  - IDLE -> SWEEP: CLEAR=1 at an edge. Pointer is set to 0.
  - SWEEP: at each edge, REGISTER[ptr] becomes 0 and ptr increments.
  - SWEEP -> IDLE: at the edge that clears register DEPTH-1.
  - CLEAR is ignored while in SWEEP.
- **BUSY.** BUSY=1 exactly while the state is SWEEP, i.e. for DEPTH cycles.
- **Write.** WRITE=1 in IDLE stores IN into REGISTER[INADDRESS] at the edge.
  - A write in the same cycle as CLEAR (still IDLE) is performed. The sweep clears it later.
- **Dropped write.** WRITE=1 while BUSY=1:
  - the write is discarded;
  - DROPPED=1 for the following cycle only.
- **Zero register.** If ZERO_REG=1:
  - a write to address 0 is silently ignored, with no DROPPED pulse;
  - OUTn is 0 whenever OUTnADDRESS=0.
- **Read.** OUTn = REGISTER[OUTnADDRESS] combinationally. Both ports may address the same register.
- **Bypass.** If BYPASS=1 and all of the following hold, then OUTn = IN (forwarding applies to each port independently):
  - RESET=1, WRITE=1, BUSY=0;
  - INADDRESS = OUTnADDRESS;
  - the zero-register rule does not apply to the address.
- **No bypass.** If BYPASS=0, the new value appears on OUTn after the write edge.
- **Width.** Data is stored unmodified at DATA_W bits. There is no sign extension or truncation. Addresses cover DEPTH exactly, so no out-of-range case exists.

## Timing
- **Write latency.** The written value is visible on OUTn:
  - 0 cycles with bypass (same cycle, combinational);
  - otherwise 1 edge after the write edge.
- **Sweep length.** CLEAR sampled at edge E0:
  - BUSY rises after E0;
  - registers 0..DEPTH-1 are cleared at edges E1..E_DEPTH;
  - BUSY falls after E_DEPTH.
  - A fresh CLEAR at E_DEPTH is ignored (still SWEEP). CLEAR at E_DEPTH+1 starts a new sweep.
- **During sweep.** Reads are valid every cycle. Cleared registers read 0; uncleared registers keep their old value.
- **DROPPED.** Asserted in the cycle after the dropped write. It is never high for a cycle without a corresponding drop.
- **Outputs after reset.** OUT1/OUT2 read 0 for all addresses one edge after the reset edge, and BUSY=DROPPED=0.

## Test plan
- **Reset.** Defaults; write 8'hFF to all 8 registers, then RESET=0 one edge -> every address reads 0, BUSY=0, DROPPED=0.
- **Write/read and bypass.**
  - Write 95 to r2 with OUT1ADDRESS=2 and BYPASS=1 -> OUT1=95 in the write cycle.
  - With BYPASS=0 -> OUT1 holds the old value until after the edge, then reads 95.
- **Sweep.**
  - Fill r0..r7 with 1..8, pulse CLEAR -> BUSY high exactly 8 cycles;
  - after edge Ek, r(k-1) reads 0 and r(k..7) unchanged;
  - all registers read 0 when BUSY falls.
- **Write during sweep.**
  - WRITE 28 to r5 in 3rd BUSY cycle -> r5 unchanged by the write, DROPPED=1 next cycle only, no bypass of 28.
  - A write coincident with CLEAR is stored, then cleared.
- **Zero register.** ZERO_REG=1: write 50 to r0 -> OUT1 with address 0 reads 0 before and after, DROPPED stays 0, r1..r7 unaffected.
- **Parametrisation and abort.**
  - DATA_W=16, ADDR_W=4: write 16'hBEEF to r15 -> reads back; CLEAR -> BUSY 16 cycles.
  - RESET=0 on 5th sweep cycle -> BUSY=0 and all registers 0 next cycle.
